// File: rtl/onchip_mem_stream_reader_if.sv
// Command, RAM-port and stream signals of the on-chip memory stream reader.
interface onchip_mem_stream_reader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 64
);
  logic                  start;
  logic [ADDR_W-1:0]     base_addr;
  logic [ADDR_W:0]       word_count;
  logic                  busy;
  logic                  done;
  logic [ADDR_W-1:0]     mem_address;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [DATA_W/8-1:0]   mem_byteenable;
  logic                  mem_clken;
  logic [DATA_W-1:0]     mem_readdata;
  logic [DATA_W-1:0]     st_data;
  logic                  st_valid;
  logic                  st_ready;
  logic                  st_last;

  modport master (
    input  start, base_addr, word_count, mem_readdata, st_ready,
    output busy, done, mem_address, mem_chipselect, mem_write,
           mem_byteenable, mem_clken, st_data, st_valid, st_last
  );

  modport slave (
    output start, base_addr, word_count, mem_readdata, st_ready,
    input  busy, done, mem_address, mem_chipselect, mem_write,
           mem_byteenable, mem_clken, st_data, st_valid, st_last
  );
endinterface

// File: rtl/onchip_mem_stream_reader.sv
// Reads a word range from a 1-cycle-latency on-chip RAM and streams it out
// through a small return FIFO that absorbs consumer backpressure.
module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
)(
  input  logic i_clk,
  input  logic i_reset_n,
  onchip_mem_stream_reader_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W+1:0]  DEPTH_V  = (PTR_W+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t              r_state, w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_issue_cnt;
  logic [ADDR_W:0]     r_beat_cnt;
  logic                r_inflight;
  logic                r_done;
  logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [PTR_W:0]      r_count;

  logic                w_issue, w_accept, w_zero_start;
  logic                w_valid, w_pop, w_last_beat, w_room;
  logic [PTR_W+1:0]    w_occ;

  // A slot is reserved at issue time, so the return write never overflows.
  assign w_occ       = {1'b0, r_count} + {{(PTR_W+1){1'b0}}, r_inflight};
  assign w_room      = w_occ < DEPTH_V;
  assign w_valid     = r_count != '0;
  assign w_pop       = w_valid && bus.st_ready;
  assign w_last_beat = w_pop && (r_beat_cnt == CNT_ONE);

  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_accept     = 1'b0;
    w_zero_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.word_count != '0) begin
            w_accept = 1'b1;
            w_next   = S_READ;
          end else begin
            w_zero_start = 1'b1;
          end
        end
      end
      S_READ: begin
        w_issue = w_room;
        if (w_issue && r_issue_cnt == CNT_ONE) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_DRAIN;
      default: w_next = S_IDLE;
    endcase
    if (r_state != S_IDLE && w_last_beat) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_zero_start || w_last_beat;
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr      <= bus.base_addr;
        r_issue_cnt <= bus.word_count;
        r_beat_cnt  <= bus.word_count;
      end else begin
        // Address stops on the final issued word so it holds there when idle.
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt - CNT_ONE;
          if (r_issue_cnt != CNT_ONE) r_addr <= r_addr + ADDR_ONE;
        end
        if (w_pop) r_beat_cnt <= r_beat_cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (r_inflight) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)      r_rptr <= r_rptr + PTR_ONE;
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_n && r_inflight) r_fifo[r_wptr] <= bus.mem_readdata;
  end

  assign bus.busy           = r_state != S_IDLE;
  assign bus.done           = r_done;
  assign bus.mem_address    = r_addr;
  assign bus.mem_chipselect = w_issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = '1;
  assign bus.mem_clken      = 1'b1;
  assign bus.st_data        = r_fifo[r_rptr];
  assign bus.st_valid       = w_valid;
  assign bus.st_last        = w_valid && (r_beat_cnt == CNT_ONE);
endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Scoreboard bench: expected beats are queued at start, popped on handshakes.
module tb_onchip_mem_stream_reader;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  onchip_mem_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW:0]   sb[$];
  logic [AW-1:0] addr_log[$];
  int cs_cnt, beat_cnt, done_cnt, max_occ;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [DW:0]   mon_exp;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {16'hC0DE, 35'd0, a};
  endfunction

  // RAM model: one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_chipselect) bus.mem_readdata <= mem_val(bus.mem_address);
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.mem_chipselect) begin
          cs_cnt++;
          addr_log.push_back(bus.mem_address);
        end
        if (cs_cnt - beat_cnt > max_occ) max_occ = cs_cnt - beat_cnt;
        if (bus.done) done_cnt++;
        if (prev_stall) begin
          n_checks++;
          if (bus.st_valid !== 1'b1 || bus.st_data !== prev_data)
            $display("FAIL hold: valid=%0b data=%h, required valid=1 data=%h",
                     bus.st_valid, bus.st_data, prev_data);
          else n_pass++;
        end
        if (bus.st_valid && bus.st_ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL beat: unexpected beat data=%h last=%0b, required none",
                     bus.st_data, bus.st_last);
          end else begin
            mon_exp = sb.pop_front();
            if ({bus.st_last, bus.st_data} !== mon_exp)
              $display("FAIL beat: last=%0b data=%h, required last=%0b data=%h",
                       bus.st_last, bus.st_data, mon_exp[DW], mon_exp[DW-1:0]);
            else n_pass++;
          end
          beat_cnt++;
        end
        prev_stall = bus.st_valid && !bus.st_ready;
        prev_data  = bus.st_data;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    cs_cnt = 0; beat_cnt = 0; done_cnt = 0; max_occ = 0;
    addr_log.delete();
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input int cnt);
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = (AW+1)'(cnt);
    for (int i = 0; i < cnt; i++)
      sb.push_back({(i == cnt - 1), mem_val(base + AW'(i))});
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < max_cyc) begin
      tick();
      k++;
    end
    n_checks++;
    if (bus.done !== 1'b1) $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, bus.done, k);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.st_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.busy, bus.done, bus.mem_chipselect, bus.st_valid, bus.st_last, bus.mem_write} !== 6'b0
        || bus.mem_address !== '0)
      $display("FAIL reset_outputs: busy/done/cs/valid/last/wr=%b addr=%0d, required 0",
               {bus.busy, bus.done, bus.mem_chipselect, bus.st_valid, bus.st_last, bus.mem_write},
               bus.mem_address);
    else n_pass++;
    n_checks++;
    if (bus.mem_byteenable !== 8'hFF || bus.mem_clken !== 1'b1)
      $display("FAIL reset_consts: be=%h clken=%b, required ff 1", bus.mem_byteenable, bus.mem_clken);
    else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] exp_v;
    clear_stats();
    bus.st_ready = 1'b1;
    start_xfer(13'd10, 5);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.mem_chipselect !== 1'b1 || bus.mem_address !== 13'd10)
      $display("FAIL basic_c1: busy=%b cs=%b addr=%0d, required 1 1 10",
               bus.busy, bus.mem_chipselect, bus.mem_address);
    else n_pass++;
    for (int cyc = 2; cyc <= 9; cyc++) begin
      tick();
      exp_v = {(cyc >= 3 && cyc <= 7), (cyc == 7), (cyc == 8), (cyc <= 7)};
      n_checks++;
      if ({bus.st_valid, bus.st_last, bus.done, bus.busy} !== exp_v)
        $display("FAIL basic_c%0d: valid/last/done/busy=%b, required %b", cyc,
                 {bus.st_valid, bus.st_last, bus.done, bus.busy}, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (beat_cnt !== 5 || done_cnt !== 1 || sb.size() !== 0)
      $display("FAIL basic_counts: beats=%0d dones=%0d left=%0d, required 5 1 0",
               beat_cnt, done_cnt, sb.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int k;
    clear_stats();
    bus.st_ready = 1'b0;
    start_xfer(13'd200, 16);
    repeat (9) tick();
    n_checks++;
    if (cs_cnt !== FD || bus.mem_chipselect !== 1'b0)
      $display("FAIL bp_stall: reads=%0d cs=%b, required %0d 0", cs_cnt, bus.mem_chipselect, FD);
    else n_pass++;
    k = 0;
    while (bus.done !== 1'b1 && k < 400) begin
      bus.st_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    bus.st_ready = 1'b1;
    tick();
    n_checks++;
    if (beat_cnt !== 16 || done_cnt !== 1 || cs_cnt !== 16 || sb.size() !== 0)
      $display("FAIL bp_counts: beats=%0d dones=%0d reads=%0d left=%0d, required 16 1 16 0",
               beat_cnt, done_cnt, cs_cnt, sb.size());
    else n_pass++;
    n_checks++;
    if (max_occ !== FD) $display("FAIL bp_occupancy: max=%0d, required %0d", max_occ, FD);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    clear_stats();
    bus.st_ready = 1'b1;
    start_xfer(13'd8190, 4);
    wait_done(50, "wrap");
    tick();
    n_checks++;
    if (addr_log.size() !== 4) $display("FAIL wrap_reads: count=%0d, required 4", addr_log.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      ea = 13'd8190 + AW'(i);
      n_checks++;
      if (addr_log[i] !== ea) $display("FAIL wrap_addr%0d: addr=%0d, required %0d", i, addr_log[i], ea);
      else n_pass++;
    end
  endtask

  task automatic test_zero();
    clear_stats();
    start_xfer(13'd5, 0);
    n_checks++;
    if ({bus.busy, bus.done, bus.mem_chipselect} !== 3'b010)
      $display("FAIL zero_c1: busy/done/cs=%b, required 010", {bus.busy, bus.done, bus.mem_chipselect});
    else n_pass++;
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || cs_cnt !== 0 || beat_cnt !== 0 || done_cnt !== 1)
      $display("FAIL zero_after: done=%b reads=%0d beats=%0d dones=%0d, required 0 0 0 1",
               bus.done, cs_cnt, beat_cnt, done_cnt);
    else n_pass++;
  endtask

  task automatic test_full();
    clear_stats();
    bus.st_ready = 1'b1;
    start_xfer(13'd100, 8192);
    wait_done(9000, "full");
    tick();
    n_checks++;
    if (beat_cnt !== 8192 || cs_cnt !== 8192 || done_cnt !== 1 || sb.size() !== 0)
      $display("FAIL full_counts: beats=%0d reads=%0d dones=%0d left=%0d, required 8192 8192 1 0",
               beat_cnt, cs_cnt, done_cnt, sb.size());
    else n_pass++;
  endtask

  task automatic test_ignored_start();
    clear_stats();
    bus.st_ready = 1'b1;
    start_xfer(13'd20, 8);
    tick();
    bus.start = 1'b1; bus.base_addr = 13'd500; bus.word_count = 14'd3;
    tick();
    bus.start = 1'b0;
    wait_done(100, "ignored");
    tick();
    n_checks++;
    if (beat_cnt !== 8 || cs_cnt !== 8 || done_cnt !== 1 || sb.size() !== 0)
      $display("FAIL ignored_counts: beats=%0d reads=%0d dones=%0d left=%0d, required 8 8 1 0",
               beat_cnt, cs_cnt, done_cnt, sb.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_stats();
    bus.st_ready = 1'b1;
    start_xfer(13'd300, 2);
    wait_done(50, "b2b_first");
    start_xfer(13'd400, 2);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.mem_chipselect !== 1'b1 || bus.mem_address !== 13'd400)
      $display("FAIL b2b_restart: busy=%b cs=%b addr=%0d, required 1 1 400",
               bus.busy, bus.mem_chipselect, bus.mem_address);
    else n_pass++;
    wait_done(50, "b2b_second");
    tick();
    n_checks++;
    if (beat_cnt !== 4 || done_cnt !== 2 || sb.size() !== 0)
      $display("FAIL b2b_counts: beats=%0d dones=%0d left=%0d, required 4 2 0",
               beat_cnt, done_cnt, sb.size());
    else n_pass++;
  endtask

  task automatic test_midreset();
    int k;
    clear_stats();
    bus.st_ready = 1'b1;
    start_xfer(13'd40, 8);
    k = 0;
    while (beat_cnt < 3 && k < 50) begin
      tick();
      k++;
    end
    n_checks++;
    if (beat_cnt !== 3) $display("FAIL midrst_wait: beats=%0d, required 3", beat_cnt);
    else n_pass++;
    reset_n = 1'b0;
    tick();
    n_checks++;
    if ({bus.busy, bus.done, bus.mem_chipselect, bus.st_valid, bus.st_last} !== 5'b0
        || bus.mem_address !== '0)
      $display("FAIL midrst_outputs: busy/done/cs/valid/last=%b addr=%0d, required 0",
               {bus.busy, bus.done, bus.mem_chipselect, bus.st_valid, bus.st_last}, bus.mem_address);
    else n_pass++;
    reset_n = 1'b1;
    sb.delete();
    clear_stats();
    repeat (5) tick();
    n_checks++;
    if (done_cnt !== 0 || beat_cnt !== 0 || cs_cnt !== 0)
      $display("FAIL midrst_quiet: dones=%0d beats=%0d reads=%0d, required 0 0 0",
               done_cnt, beat_cnt, cs_cnt);
    else n_pass++;
    start_xfer(13'd7, 3);
    wait_done(50, "midrst_restart");
    tick();
    n_checks++;
    if (beat_cnt !== 3 || done_cnt !== 1 || sb.size() !== 0)
      $display("FAIL midrst_restart: beats=%0d dones=%0d left=%0d, required 3 1 0",
               beat_cnt, done_cnt, sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_ignored_start();
    test_back_to_back();
    test_midreset();
    test_full();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
